wb_stage_buffer: RTL and testbench
==================================

# wb_stage_buffer

Parametrised writeback-stage pipeline register for the Y86 pipeline, between the memory stage and the register-file write port. Holds one architectural W entry plus a one-entry skid slot behind a valid/ready handshake, so upstream readiness never depends combinationally on downstream. Adds flush, stall and sticky exception halt, and a retired-instruction counter.

## Interface
Parameters:
- VAL_W, 64, width of valE/valM
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- m_valid  in  1  upstream entry valid
- m_ready  out  1  buffer can accept
- m_status  in  2  status (AOK=0, HLT=1, ADR=2, INS=3)
- m_icode  in  4  instruction code
- m_valE, m_valM  in  VAL_W  ALU / memory results
- m_destE, m_destM  in  4  destination registers (0xF = RNONE)
- W_stall  in  1  freeze entire buffer this cycle
- W_flush  in  1  discard all non-halted contents
- W_valid  out  1  W entry valid
- W_ready  in  1  register file consumes W entry
- W_status, W_icode, W_valE, W_valM, W_destE, W_destM  out  as inputs  W entry fields
- W_halted  out  1  sticky: non-AOK entry reached W
- W_occupancy  out  2  entries held (0..2)
- W_retired  out  CNT_W  count of consumed non-NOP entries

## Operation
- Storage: main entry (drives W_*) and skid entry; each has a valid bit.
- m_ready = !skid_valid && !W_halted && !W_stall; registered state only, never W_ready.
- Accept = m_valid && m_ready. Consume = W_valid && W_ready && !W_stall && !W_halted.
- Priority each cycle: reset > W_flush > W_stall > normal.
- W_flush: both valid bits cleared; fields reset to bubble (icode NOP=4'h1, status AOK, dest RNONE, vals 0); accept suppressed (m_ready still as above, entry dropped). Ignored while W_halted.
- W_stall: no state changes; W_* held.
- Normal:
  - main empty or consumed, skid empty: accepted entry loads main.
  - main consumed, skid full: skid moves to main; skid empty (no accept, m_ready was 0).
  - main full, not consumed: accepted entry loads skid.
- Halt: when main valid with W_status != AOK, W_halted sets next cycle and stays until reset; main held, consume blocked, m_ready 0. Skid contents frozen.
- W_retired increments by 1 on each consume with W_icode != NOP; wraps at 2^CNT_W.
- W_occupancy = main_valid + skid_valid.

## Timing
- Reset (async assert, sync-safe deassert handled upstream): W_valid 0, skid empty, W_halted 0, W_status AOK, W_icode NOP, W_destE/W_destM 0xF, W_valE/W_valM 0, W_retired 0, W_occupancy 0.
- Latency: accept in cycle n -> W_valid with entry in n+1 when main was empty or consumed in n.
- Sustained throughput 1 entry/cycle with W_ready held high.
- W_ready low one cycle: one entry parks in skid, m_ready low next cycle, full rate resumes after.
- Simultaneous consume+accept with empty skid: new entry replaces main, no bubble.
- Halt detection: non-AOK entry visible on W_* in cycle n, W_halted high from n+1; W_ready in cycle n is ignored (consume blocked combinationally by status).
- Reset mid-operation clears everything including halted state and counter.

## Structure
- Shared package y86_pkg: status codes (AOK/HLT/ADR/INS), ICODE_NOP, ICODE_HALT, RNONE, packed entry struct (status, icode, valE, valM, destE, destM) parametrised via VAL_W-typed fields.
- One sub-module, wb_entry_slot: single entry register with valid bit, load, clear-to-bubble; instantiated twice (main, skid).

## Test plan
- Reset: assert rst_n=0 mid-stream with occupancy 2 -> all outputs at reset values immediately, W_retired 0.
- Streaming: 8 entries icode 6, W_ready=1 -> W_valid one cycle after each accept, W_retired = 8, occupancy never 2.
- Backpressure: W_ready=0 for 2 cycles during stream -> second entry held in skid, m_ready 0, no entry lost or duplicated, order preserved.
- Stall vs flush: W_stall=1 with occupancy 2 -> outputs frozen; then W_flush=1 -> W_valid 0, occupancy 0, W_icode 4'h1, W_destE 0xF.
- Exception: entry status ADR reaches W with W_ready=1 -> not consumed, W_halted 1 next cycle, m_ready 0, W_flush ignored until reset.
- Counter: 3 NOP + 2 icode 3 consumed -> W_retired = 2; preload wrap with CNT_W=4 after 16 retirements -> 0.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86 pipeline types: status codes, special icodes/registers, W entry struct.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package y86_pkg;

    // Widest value field any stage instance may use; narrower instances
    // zero-extend into the struct and truncate on the way out.
    localparam int VAL_W_MAX = 64;

    typedef enum logic [1:0] {
        STAT_AOK = 2'd0,
        STAT_HLT = 2'd1,
        STAT_ADR = 2'd2,
        STAT_INS = 2'd3
    } status_t;

    localparam logic [3:0] ICODE_HALT = 4'h0;
    localparam logic [3:0] ICODE_NOP  = 4'h1;
    localparam logic [3:0] RNONE      = 4'hF;

    typedef struct packed {
        status_t                status;
        logic [3:0]             icode;
        logic [VAL_W_MAX-1:0]   valE;
        logic [VAL_W_MAX-1:0]   valM;
        logic [3:0]             destE;
        logic [3:0]             destM;
    } entry_t;

    // Pipeline bubble: harmless NOP that writes no register.
    function automatic entry_t bubble_entry();
        entry_t e;
        e.status = STAT_AOK;
        e.icode  = ICODE_NOP;
        e.valE   = '0;
        e.valM   = '0;
        e.destE  = RNONE;
        e.destM  = RNONE;
        return e;
    endfunction

endpackage

// File: rtl/wb_entry_slot.sv
// Single W-stage entry register with valid bit; load or clear-to-bubble.
// Latency: 1 cycle from load_i to dat_o/vld_o.
// Backpressure: none; the owner decides when to load or clear.
module wb_entry_slot
    import y86_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   load_i,
    input  logic   clr_i,
    input  entry_t dat_i,
    output logic   vld_o,
    output entry_t dat_o
);

    logic   vld_q, vld_d;
    entry_t dat_q, dat_d;

    // Clear wins over load so a flush can never be overridden by a refill.
    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (clr_i) begin
            vld_d = 1'b0;
            dat_d = bubble_entry();
        end else if (load_i) begin
            vld_d = 1'b1;
            dat_d = dat_i;
        end
    end

    // Entry state register, reset to an invalid bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            dat_q <= bubble_entry();
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign vld_o = vld_q;
    assign dat_o = dat_q;

endmodule

// File: rtl/wb_stage_buffer.sv
// Y86 writeback pipeline register: main W entry + skid slot, flush/stall, sticky halt, retire count.
// Latency: 1 cycle accept-to-W_valid when main is empty or consumed in the accept cycle.
// Backpressure: m_ready is purely registered (skid empty, not halted) gated by W_stall; never W_ready.
module wb_stage_buffer
    import y86_pkg::*;
#(
    parameter int VAL_W = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             m_valid,
    output logic             m_ready,
    input  logic [1:0]       m_status,
    input  logic [3:0]       m_icode,
    input  logic [VAL_W-1:0] m_valE,
    input  logic [VAL_W-1:0] m_valM,
    input  logic [3:0]       m_destE,
    input  logic [3:0]       m_destM,
    input  logic             W_stall,
    input  logic             W_flush,
    output logic             W_valid,
    input  logic             W_ready,
    output logic [1:0]       W_status,
    output logic [3:0]       W_icode,
    output logic [VAL_W-1:0] W_valE,
    output logic [VAL_W-1:0] W_valM,
    output logic [3:0]       W_destE,
    output logic [3:0]       W_destM,
    output logic             W_halted,
    output logic [1:0]       W_occupancy,
    output logic [CNT_W-1:0] W_retired
);

    entry_t in_entry;
    entry_t main_src;
    entry_t main_dat, skid_dat;
    logic   main_vld, skid_vld;
    logic   main_load, main_clr, skid_load, skid_clr;
    logic   accept, consume;

    logic             halted_q, halted_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    // Pack the upstream fields into one entry.
    always_comb begin
        in_entry        = bubble_entry();
        in_entry.status = status_t'(m_status);
        in_entry.icode  = m_icode;
        in_entry.valE   = VAL_W_MAX'(m_valE);
        in_entry.valM   = VAL_W_MAX'(m_valM);
        in_entry.destE  = m_destE;
        in_entry.destM  = m_destM;
    end

    assign m_ready = !skid_vld && !halted_q && !W_stall;
    assign accept  = m_valid && m_ready;
    // A non-AOK entry is never handed to the register file, even before halt registers.
    assign consume = main_vld && W_ready && !W_stall && !halted_q
                     && (main_dat.status == STAT_AOK);

    // Slot control: halted freezes everything, then flush, then stall, then normal flow.
    always_comb begin
        main_load = 1'b0;
        main_clr  = 1'b0;
        skid_load = 1'b0;
        skid_clr  = 1'b0;
        main_src  = in_entry;
        halted_d  = halted_q;
        retired_d = retired_q;
        if (halted_q) begin
            halted_d = 1'b1;
        end else if (W_flush) begin
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else if (!W_stall) begin
            if (main_vld && (main_dat.status != STAT_AOK)) begin
                halted_d = 1'b1;
            end
            if (consume && (main_dat.icode != ICODE_NOP)) begin
                retired_d = retired_q + CNT_W'(1);
            end
            if (consume && skid_vld) begin
                // m_ready was low, so no new entry competes with the skid.
                main_load = 1'b1;
                main_src  = skid_dat;
                skid_clr  = 1'b1;
            end else if (accept && (!main_vld || consume)) begin
                main_load = 1'b1;
            end else if (accept) begin
                skid_load = 1'b1;
            end else if (consume) begin
                main_clr = 1'b1;
            end
        end
    end

    // Sticky halt flag and retired-instruction counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted_q  <= 1'b0;
            retired_q <= '0;
        end else begin
            halted_q  <= halted_d;
            retired_q <= retired_d;
        end
    end

    wb_entry_slot u_main (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (main_load),
        .clr_i  (main_clr),
        .dat_i  (main_src),
        .vld_o  (main_vld),
        .dat_o  (main_dat)
    );

    wb_entry_slot u_skid (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (skid_load),
        .clr_i  (skid_clr),
        .dat_i  (in_entry),
        .vld_o  (skid_vld),
        .dat_o  (skid_dat)
    );

    assign W_valid     = main_vld;
    assign W_status    = main_dat.status;
    assign W_icode     = main_dat.icode;
    assign W_valE      = main_dat.valE[VAL_W-1:0];
    assign W_valM      = main_dat.valM[VAL_W-1:0];
    assign W_destE     = main_dat.destE;
    assign W_destM     = main_dat.destM;
    assign W_halted    = halted_q;
    assign W_occupancy = {1'b0, main_vld} + {1'b0, skid_vld};
    assign W_retired   = retired_q;

endmodule

// File: tb/tb_wb_stage_buffer.sv
module tb_wb_stage_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m_valid;
    logic [1:0]  m_status;
    logic [3:0]  m_icode;
    logic [63:0] m_valE, m_valM;
    logic [3:0]  m_destE, m_destM;
    logic        W_stall, W_flush, W_ready;

    logic        m_ready, W_valid, W_halted;
    logic [1:0]  W_status, W_occupancy;
    logic [3:0]  W_icode, W_destE, W_destM;
    logic [63:0] W_valE, W_valM;
    logic [31:0] W_retired;

    logic        d2_m_ready, d2_W_valid, d2_W_halted;
    logic [1:0]  d2_W_status, d2_W_occupancy;
    logic [3:0]  d2_W_icode, d2_W_destE, d2_W_destM;
    logic [63:0] d2_W_valE, d2_W_valM;
    logic [3:0]  d2_W_retired;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    wb_stage_buffer #(.VAL_W(64), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .m_valid(m_valid), .m_ready(m_ready),
        .m_status(m_status), .m_icode(m_icode), .m_valE(m_valE), .m_valM(m_valM),
        .m_destE(m_destE), .m_destM(m_destM), .W_stall(W_stall), .W_flush(W_flush),
        .W_valid(W_valid), .W_ready(W_ready), .W_status(W_status), .W_icode(W_icode),
        .W_valE(W_valE), .W_valM(W_valM), .W_destE(W_destE), .W_destM(W_destM),
        .W_halted(W_halted), .W_occupancy(W_occupancy), .W_retired(W_retired)
    );

    // Same stimulus, 4-bit counter to observe wrap.
    wb_stage_buffer #(.VAL_W(64), .CNT_W(4)) dut_w4 (
        .clk(clk), .rst_n(rst_n), .m_valid(m_valid), .m_ready(d2_m_ready),
        .m_status(m_status), .m_icode(m_icode), .m_valE(m_valE), .m_valM(m_valM),
        .m_destE(m_destE), .m_destM(m_destM), .W_stall(W_stall), .W_flush(W_flush),
        .W_valid(d2_W_valid), .W_ready(W_ready), .W_status(d2_W_status), .W_icode(d2_W_icode),
        .W_valE(d2_W_valE), .W_valM(d2_W_valM), .W_destE(d2_W_destE), .W_destM(d2_W_destM),
        .W_halted(d2_W_halted), .W_occupancy(d2_W_occupancy), .W_retired(d2_W_retired)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] st, input logic [3:0] ic, input logic [63:0] ve);
        m_valid  = v;
        m_status = st;
        m_icode  = ic;
        m_valE   = ve;
        m_valM   = ~ve;
        m_destE  = 4'h2;
        m_destM  = 4'h3;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        W_stall = 1'b0;
        W_flush = 1'b0;
        W_ready = 1'b0;
        drive(1'b0, 2'd0, 4'h1, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic check_reset_values(input string tag);
        tests++;
        if (W_valid !== 1'b0 || W_occupancy !== 2'd0 || W_halted !== 1'b0 || W_status !== 2'd0 ||
            W_icode !== 4'h1 || W_destE !== 4'hF || W_destM !== 4'hF || W_valE !== 64'd0 ||
            W_valM !== 64'd0 || W_retired !== 32'd0) begin
            fails++;
            $display("FAIL %s: got valid=%b occ=%0d halt=%b st=%0d ic=%h dE=%h dM=%h vE=%0h vM=%0h ret=%0d required 0/0/0/0/1/f/f/0/0/0",
                     tag, W_valid, W_occupancy, W_halted, W_status, W_icode, W_destE, W_destM, W_valE, W_valM, W_retired);
        end
    endtask

    task automatic test_reset();
        do_reset();
        check_reset_values("reset_initial");
        tests++;
        if (m_ready !== 1'b1) begin fails++; $display("FAIL reset_m_ready: got %b required 1", m_ready); end
        // Build up occupancy 2 with a nonzero counter, then reset asynchronously.
        W_ready = 1'b1;
        drive(1'b1, 2'd0, 4'h6, 64'd10); step();
        drive(1'b1, 2'd0, 4'h6, 64'd11); step();
        W_ready = 1'b0;
        drive(1'b1, 2'd0, 4'h6, 64'd12); step();
        drive(1'b0, 2'd0, 4'h1, 64'd0);
        tests++;
        if (W_occupancy !== 2'd2 || W_retired !== 32'd1) begin
            fails++; $display("FAIL reset_precond: got occ=%0d ret=%0d required 2/1", W_occupancy, W_retired);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("reset_async_mid");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_streaming();
        do_reset();
        W_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 2'd0, 4'h6, 64'(i + 32));
            step();
            tests++;
            if (W_valid !== 1'b1 || W_valE !== 64'(i + 32) || W_occupancy === 2'd2) begin
                fails++;
                $display("FAIL stream_%0d: got valid=%b valE=%0d occ=%0d required 1/%0d/<2", i, W_valid, W_valE, W_occupancy, i + 32);
            end
        end
        drive(1'b0, 2'd0, 4'h1, 64'd0);
        step();
        tests++;
        if (W_retired !== 32'd8 || W_valid !== 1'b0) begin
            fails++; $display("FAIL stream_retired: got ret=%0d valid=%b required 8/0", W_retired, W_valid);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        W_ready = 1'b1;
        drive(1'b1, 2'd0, 4'h6, 64'd100); step();
        W_ready = 1'b0;
        drive(1'b1, 2'd0, 4'h6, 64'd101); step();
        tests++;
        if (W_occupancy !== 2'd2 || m_ready !== 1'b0 || W_valE !== 64'd100) begin
            fails++; $display("FAIL bp_skid: got occ=%0d m_ready=%b valE=%0d required 2/0/100", W_occupancy, m_ready, W_valE);
        end
        drive(1'b1, 2'd0, 4'h6, 64'd102); step();
        tests++;
        if (W_occupancy !== 2'd2 || W_valE !== 64'd100 || W_valM !== ~64'd100) begin
            fails++; $display("FAIL bp_hold: got occ=%0d valE=%0d valM=%0h required 2/100/%0h", W_occupancy, W_valE, W_valM, ~64'd100);
        end
        W_ready = 1'b1;
        step();
        tests++;
        if (W_valE !== 64'd101 || W_occupancy !== 2'd1 || m_ready !== 1'b1) begin
            fails++; $display("FAIL bp_skid_to_main: got valE=%0d occ=%0d m_ready=%b required 101/1/1", W_valE, W_occupancy, m_ready);
        end
        step();
        tests++;
        if (W_valE !== 64'd102 || W_valid !== 1'b1 || W_occupancy !== 2'd1) begin
            fails++; $display("FAIL bp_resume: got valE=%0d valid=%b occ=%0d required 102/1/1", W_valE, W_valid, W_occupancy);
        end
        drive(1'b0, 2'd0, 4'h1, 64'd0);
        step();
        tests++;
        if (W_valid !== 1'b0 || W_retired !== 32'd3) begin
            fails++; $display("FAIL bp_drain: got valid=%b ret=%0d required 0/3", W_valid, W_retired);
        end
    endtask

    task automatic test_stall_flush();
        do_reset();
        drive(1'b1, 2'd0, 4'h6, 64'd200); step();
        drive(1'b1, 2'd0, 4'h6, 64'd201); step();
        drive(1'b1, 2'd0, 4'h6, 64'd202);
        W_stall = 1'b1;
        W_ready = 1'b1;
        step();
        step();
        tests++;
        if (W_occupancy !== 2'd2 || W_valE !== 64'd200 || m_ready !== 1'b0 || W_retired !== 32'd0) begin
            fails++; $display("FAIL stall_frozen: got occ=%0d valE=%0d m_ready=%b ret=%0d required 2/200/0/0", W_occupancy, W_valE, m_ready, W_retired);
        end
        W_stall = 1'b0;
        W_flush = 1'b1;
        step();
        W_flush = 1'b0;
        drive(1'b0, 2'd0, 4'h1, 64'd0);
        tests++;
        if (W_valid !== 1'b0 || W_occupancy !== 2'd0 || W_icode !== 4'h1 || W_destE !== 4'hF || W_retired !== 32'd0) begin
            fails++; $display("FAIL flush_bubble: got valid=%b occ=%0d ic=%h dE=%h ret=%0d required 0/0/1/f/0", W_valid, W_occupancy, W_icode, W_destE, W_retired);
        end
    endtask

    task automatic test_exception();
        do_reset();
        W_ready = 1'b1;
        drive(1'b1, 2'd2, 4'h5, 64'd300); step();
        drive(1'b0, 2'd0, 4'h1, 64'd0);
        tests++;
        if (W_valid !== 1'b1 || W_status !== 2'd2 || W_halted !== 1'b0) begin
            fails++; $display("FAIL exc_visible: got valid=%b st=%0d halt=%b required 1/2/0", W_valid, W_status, W_halted);
        end
        step();
        tests++;
        if (W_halted !== 1'b1 || W_valid !== 1'b1 || m_ready !== 1'b0 || W_retired !== 32'd0) begin
            fails++; $display("FAIL exc_halted: got halt=%b valid=%b m_ready=%b ret=%0d required 1/1/0/0", W_halted, W_valid, m_ready, W_retired);
        end
        W_flush = 1'b1;
        drive(1'b1, 2'd0, 4'h6, 64'd301);
        step();
        step();
        W_flush = 1'b0;
        drive(1'b0, 2'd0, 4'h1, 64'd0);
        tests++;
        if (W_halted !== 1'b1 || W_valid !== 1'b1 || W_occupancy !== 2'd1 || W_valE !== 64'd300) begin
            fails++; $display("FAIL exc_flush_ignored: got halt=%b valid=%b occ=%0d valE=%0d required 1/1/1/300", W_halted, W_valid, W_occupancy, W_valE);
        end
        do_reset();
        tests++;
        if (W_halted !== 1'b0 || W_valid !== 1'b0) begin
            fails++; $display("FAIL exc_reset_clears: got halt=%b valid=%b required 0/0", W_halted, W_valid);
        end
    endtask

    task automatic test_counter();
        logic [3:0] icodes [5];
        icodes[0] = 4'h1; icodes[1] = 4'h3; icodes[2] = 4'h1; icodes[3] = 4'h1; icodes[4] = 4'h3;
        do_reset();
        W_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 2'd0, icodes[i], 64'(i)); step();
        end
        drive(1'b0, 2'd0, 4'h1, 64'd0);
        step();
        tests++;
        if (W_retired !== 32'd2) begin
            fails++; $display("FAIL cnt_skip_nop: got ret=%0d required 2", W_retired);
        end
        do_reset();
        W_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 2'd0, 4'h6, 64'(i)); step();
        end
        drive(1'b0, 2'd0, 4'h1, 64'd0);
        step();
        tests++;
        if (W_retired !== 32'd16 || d2_W_retired !== 4'd0) begin
            fails++; $display("FAIL cnt_wrap: got ret32=%0d ret4=%0d required 16/0", W_retired, d2_W_retired);
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_stall_flush();
        test_exception();
        test_counter();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
